// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment driver with per-slot anti-ghosting guard time.
// Define SSEG_LZB_EN to compile in leading-zero blanking.
module sseg_scan_mux #(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE_W   = 18,
  parameter int GUARD_CYCLES = 16,
  localparam int IDX_W       = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [PRESCALE_W-1:0] presc_reg;
  logic [PRESCALE_W-1:0] presc_next;
  logic [IDX_W-1:0]      idx_reg;
  logic [IDX_W-1:0]      idx_next;
  logic                  slot_end;
  logic                  in_guard;

  logic [4*N_DIGITS-1:0] hex_reg;
  logic [N_DIGITS-1:0]   dp_reg;
  logic [N_DIGITS-1:0]   blank_reg;
  logic [3:0]            hex_arr [N_DIGITS];
  logic [N_DIGITS-1:0]   digit_blank;

  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   an_sel;

  logic [N_DIGITS-1:0]   an_reg;
  logic [N_DIGITS-1:0]   an_next;
  logic [7:0]            sseg_reg;
  logic [7:0]            sseg_next;

  // Shadow registers: the display only ever sees data latched by load.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_reg   <= '0;
      dp_reg    <= '0;
      blank_reg <= '1;
    end else if (load) begin
      hex_reg   <= hex_in;
      dp_reg    <= dp_in;
      blank_reg <= blank_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_hex_view
      assign hex_arr[gi] = hex_reg[4*gi +: 4];
    end
  endgenerate

  // Slot timing: free-running prescaler, digit index steps on its wrap.
  assign slot_end   = (presc_reg == '1);
  assign presc_next = presc_reg + PRESCALE_W'(1);

  always_comb begin
    idx_next = idx_reg;
    if (slot_end) begin
      if (idx_reg == LAST_IDX) begin
        idx_next = '0;
      end else begin
        idx_next = idx_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else begin
      presc_reg <= presc_next;
      idx_reg   <= idx_next;
    end
  end

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [PRESCALE_W-1:0] GUARD_V = PRESCALE_W'(GUARD_CYCLES);
      assign in_guard = (presc_reg < GUARD_V);
    end
  endgenerate

`ifdef SSEG_LZB_EN
  // zero_above[i]: digit i and every digit above it are 0 with no dp lit.
  logic [N_DIGITS:1] zero_above;
  assign zero_above[N_DIGITS] = 1'b1;
  generate
    for (gi = 1; gi < N_DIGITS; gi++) begin : g_lzb
      assign zero_above[gi]  = zero_above[gi+1] & (hex_arr[gi] == 4'h0) & ~dp_reg[gi];
      assign digit_blank[gi] = blank_reg[gi] | zero_above[gi];
    end
  endgenerate
  assign digit_blank[0] = blank_reg[0];
`else
  assign digit_blank = blank_reg;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Select the active digit by compare rather than array index so that
  // non-power-of-2 digit counts never address a missing entry.
  always_comb begin
    cur_hex   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    an_sel    = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        cur_hex   = hex_arr[i];
        cur_dp    = dp_reg[i];
        cur_blank = digit_blank[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    an_next   = '1;
    sseg_next = 8'hFF;
    if (!in_guard) begin
      an_next = an_sel;
      if (!cur_blank) begin
        sseg_next = {~cur_dp, seg_decode(cur_hex)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_reg   <= '1;
      sseg_reg <= 8'hFF;
    end else begin
      an_reg   <= an_next;
      sseg_reg <= sseg_next;
    end
  end

  assign an        = an_reg;
  assign sseg      = sseg_reg;
  assign digit_idx = idx_reg;

endmodule

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
- REQ-001: Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
- REQ-002: Parameter PRESCALE_W, default 18: width of the slot prescaler; each digit slot lasts 2^PRESCALE_W clk cycles.
- REQ-003: Parameter GUARD_CYCLES, default 16: anti-ghosting dead time at the start of each slot, in clk cycles; 0 disables it; must be less than 2^PRESCALE_W.
- REQ-004: Port clk, input, 1: single clock; all logic is rising-edge clk.
- REQ-005: Port reset, input, 1: synchronous, active-high reset.
- REQ-006: Port load, input, 1: capture strobe for hex_in, dp_in and blank_in.
- REQ-007: Port hex_in, input, 4*N_DIGITS: digit i value in bits [4i+3:4i]; digit 0 is least significant (rightmost).
- REQ-008: Port dp_in, input, N_DIGITS: per-digit decimal point, active-high.
- REQ-009: Port blank_in, input, N_DIGITS: per-digit forced blank, active-high.
- REQ-010: Port an, output, N_DIGITS: digit anode enables, active-low, registered.
- REQ-011: Port sseg, output, 8: segments, active-low, registered; bit 7 is dp; bits [6:0] are segments a..g (bit 6 = a).
- REQ-012: Port digit_idx, output, clog2(N_DIGITS), minimum 1 bit: index of the current slot, registered.

Function
- REQ-013: On a clk edge with load=1, the shadow registers SHALL capture hex_in, dp_in and blank_in; with load=0 they SHALL hold; inputs SHALL be ignored while load=0.
- REQ-014: The prescaler SHALL increment every cycle and wrap from 2^PRESCALE_W-1 to 0.
- REQ-015: digit_idx SHALL advance by 1 on the cycle the prescaler wraps, and SHALL wrap from N_DIGITS-1 to 0; it SHALL never take values of N_DIGITS or above, even when N_DIGITS is not a power of 2.
- REQ-016: an and sseg SHALL be registered from the current digit_idx, prescaler and shadow state, giving 1 cycle of latency; a load SHALL become visible on the outputs 2 edges after the load edge.
- REQ-017: The active digit SHALL drive an[digit_idx]=0 and all other an bits 1, except while prescaler < GUARD_CYCLES, when an SHALL be all 1 and sseg SHALL be 8'hFF.
- REQ-018: Segment encoding of sseg[6:0] (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- REQ-019: sseg[7] SHALL equal the inverse of the shadow dp for the active digit (dp lit drives 0).
- REQ-020: A blanked digit SHALL drive sseg=8'hFF with its anode still asserted, so that scan timing is unchanged.
- REQ-021: If load coincides with a slot change, the new slot SHALL display the newly captured data from the following edge; no output cycle SHALL mix old and new data for one digit.

Reset
- REQ-022: While reset=1 at a clk edge:
  - prescaler=0, digit_idx=0
  - an all 1, sseg=8'hFF
  - shadow hex=0, dp=0, blank all 1
- REQ-023: Reset SHALL take priority over a simultaneous load.
- REQ-024: Reset mid-slot or mid-guard SHALL restart scanning at digit 0 with a full guard period on the first edge after reset deasserts.

Configuration
- REQ-025: Macro SSEG_LZB_EN SHALL compile in leading-zero blanking.
- REQ-026: With SSEG_LZB_EN defined, digit i>0 SHALL be blanked when the shadow hex of digit i and of every digit above it is 0 and none of those digits has dp set; digit 0 SHALL never be LZB-blanked; explicit blank_in still applies.
- REQ-027: Without SSEG_LZB_EN, only blank_in SHALL blank digits, and no LZB logic SHALL be present.

Verification (N_DIGITS=4, PRESCALE_W=4, GUARD_CYCLES=2 unless stated)
- REQ-028: Reset, then load hex_in=16'h12AF, dp_in=0, blank_in=0 -> across slots 0..3, sseg[6:0]=0111000, 0001000, 0010010, 1001111 with an=1110, 1101, 1011, 0111.
- REQ-029: Observe prescaler values 0-1 of every slot -> an=1111 and sseg=FF; from value 2 onward the digit is driven; each slot is exactly 16 cycles.
- REQ-030: Load dp_in=4'b0100, blank_in=4'b0001 -> digit 2 has sseg[7]=0; digit 0 drives sseg=FF with an=1110.
- REQ-031: N_DIGITS=3 -> digit_idx sequence is 0,1,2,0 and an never equals 3'b111 outside guard periods.
- REQ-032: Assert reset mid-slot 2 with load=1 -> shadow is cleared, outputs are FF/all 1 for the reset edge, and scanning resumes at digit 0.
- REQ-033: With SSEG_LZB_EN, load hex_in=16'h0005 -> digits 3..1 blank and digit 0 shows 0100100; hex_in=16'h0000 -> only digit 0 shows 0000001; hex_in=16'h0005 with dp_in=4'b0100 -> digits 3 blank and digits 2..0 lit.
